// File: rtl/linear_interp_upsampler.sv
// Linear-interpolating upsampler: expands a stream of unsigned samples by
// 2**FACTOR_LOG2, emitting FACTOR evenly spaced points from each held sample
// toward the next accepted one. A flush emits the held sample once and idles.
module linear_interp_upsampler #(
  parameter int DATA_W      = 8,
  parameter int FACTOR_LOG2 = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  // Width of the signed product (cur - prev) * k.
  localparam int PW = DATA_W + 1 + FACTOR_LOG2;

  typedef enum logic [1:0] {
    IDLE,
    PRIMED,
    EMIT,
    FLUSH
  } state_t;

  state_t                 state, state_nx;
  logic [DATA_W-1:0]      prev, prev_nx;
  logic [DATA_W-1:0]      cur, cur_nx;
  logic [FACTOR_LOG2-1:0] k, k_nx;
  logic [FACTOR_LOG2-1:0] k_inc;
  logic                   out_valid_nx;
  logic [DATA_W-1:0]      out_data_nx;
  logic                   accept;
  logic                   handshake;

  // prev + floor((cur - prev) * k / FACTOR); the result always stays between
  // prev and cur, so truncation back to DATA_W never wraps.
  function automatic logic [DATA_W-1:0] interp(
    input logic [DATA_W-1:0]      p,
    input logic [DATA_W-1:0]      c,
    input logic [FACTOR_LOG2-1:0] kk
  );
    logic signed [PW-1:0] pe;
    logic signed [PW-1:0] ce;
    logic signed [PW-1:0] ke;
    logic signed [PW-1:0] prod;
    pe   = signed'({{(FACTOR_LOG2 + 1){1'b0}}, p});
    ce   = signed'({{(FACTOR_LOG2 + 1){1'b0}}, c});
    ke   = signed'({{(DATA_W + 1){1'b0}}, kk});
    prod = (ce - pe) * ke;
    return DATA_W'(pe + (prod >>> FACTOR_LOG2));
  endfunction

  // Input side is open only while no output run is in progress, and never in reset.
  always_comb begin
    in_ready = !reset && ((state == IDLE) || (state == PRIMED));
  end

  // Next-state and next-register computation for the interpolation FSM.
  always_comb begin
    state_nx     = state;
    prev_nx      = prev;
    cur_nx       = cur;
    k_nx         = k;
    out_valid_nx = out_valid;
    out_data_nx  = out_data;
    accept       = in_valid && in_ready;
    handshake    = out_valid && out_ready;
    k_inc        = k + 1'b1;

    case (state)
      IDLE: begin
        if (accept) begin
          prev_nx  = in_data;
          state_nx = PRIMED;
        end
      end

      PRIMED: begin
        if (accept) begin
          cur_nx       = in_data;
          k_nx         = '0;
          out_data_nx  = prev;
          out_valid_nx = 1'b1;
          state_nx     = EMIT;
        end else if (flush) begin
          out_data_nx  = prev;
          out_valid_nx = 1'b1;
          state_nx     = FLUSH;
        end
      end

      EMIT: begin
        if (handshake) begin
          if (k == '1) begin
            prev_nx      = cur;
            out_valid_nx = 1'b0;
            state_nx     = PRIMED;
          end else begin
            k_nx        = k_inc;
            out_data_nx = interp(prev, cur, k_inc);
          end
        end
      end

      FLUSH: begin
        if (handshake) begin
          out_valid_nx = 1'b0;
          state_nx     = IDLE;
        end
      end

      default: begin
        state_nx     = IDLE;
        out_valid_nx = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset clears everything and drops out_valid at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      prev      <= '0;
      cur       <= '0;
      k         <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state     <= state_nx;
      prev      <= prev_nx;
      cur       <= cur_nx;
      k         <= k_nx;
      out_valid <= out_valid_nx;
      out_data  <= out_data_nx;
    end
  end

endmodule

// File: doc/linear_interp_upsampler.md
Name: linear_interp_upsampler

Overview:
- Expands a stream of 8-bit samples by an integer factor, inserting linearly interpolated points between consecutive accepted samples.
- Intended to feed reconstructed-rate data into downstream pixel/sample processing, driven by the averaged output of the 1-D convolution filter.
- Streaming valid/ready on both sides.
- A flush input drains the last held sample.

Parameters:
- DATA_W, 8: sample width (unsigned).
- FACTOR_LOG2, 2: log2 of the upsample factor. FACTOR = 2**FACTOR_LOG2. Legal range is 1..4.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept an input sample.
- in_data  in  DATA_W  input sample, unsigned.
- flush  in  1  request emission of the held sample and return to IDLE.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  DATA_W  interpolated output sample, unsigned.

Behaviour:
- States: IDLE (no previous sample), PRIMED (prev held), EMIT (interpolating prev to cur), FLUSH (emitting prev once).
- Reset (async): state=IDLE, prev=0, cur=0, k=0, out_valid=0, out_data=0. in_ready=0 while reset is asserted.
- in_ready is combinational: 1 in IDLE and PRIMED, 0 in EMIT and FLUSH. It does not depend on out_ready.
- Accept = in_valid && in_ready.
- Output handshake = out_valid && out_ready.
- IDLE + accept: prev<=in_data, go to PRIMED. No output is produced.
- PRIMED + accept: cur<=in_data, k<=0, out_data<=prev, out_valid<=1, go to EMIT. The first output is visible the cycle after the accept edge.
- EMIT on output handshake with k<FACTOR-1: k<=k+1, out_data<=interp(k+1).
- EMIT on output handshake with k==FACTOR-1: prev<=cur, out_valid<=0, go to PRIMED.
- interp(k) = prev + ((cur - prev) * k) >>> FACTOR_LOG2.
  - Difference is signed, DATA_W+1 bits; product is DATA_W+1+FACTOR_LOG2 bits.
  - Arithmetic shift gives floor rounding (toward minus infinity).
  - The result always lies within [min(prev,cur), max(prev,cur)]. Truncate to DATA_W with no saturation.
- interp(0)=prev. cur itself is never emitted in EMIT; it becomes interp(0) of the next segment.
- Per segment: exactly FACTOR outputs per accepted sample after the first. Minimum FACTOR+1 cycles per input sample.
- Backpressure: while out_valid && !out_ready, out_data and k hold stable and no input is accepted.
- PRIMED + flush && !in_valid: out_data<=prev, out_valid<=1, go to FLUSH.
- FLUSH on output handshake: out_valid<=0, go to IDLE. prev is retained but treated as absent.
- PRIMED with flush and in_valid both high: the sample is accepted and flush is ignored that cycle.
- flush in IDLE, EMIT or FLUSH is ignored and not remembered.
- in_data equal to prev: FACTOR identical outputs.
- Reset asserted mid-EMIT or mid-FLUSH:
  - out_valid drops immediately (asynchronously).
  - The segment is discarded.
  - After reset, the first accepted sample only primes.
- No output beat is ever duplicated or skipped, regardless of out_ready gaps.

Test Plan:
- FACTOR_LOG2=2, out_ready=1: inputs 0, 100, 60 → outputs 0,25,50,75 then 100,90,80,70. No output follows the first sample alone. in_ready low for exactly 4 cycles per segment.
- Negative floor: prev=60, input 57 → outputs 60,59,58,57. Check: -3>>>2=-1, -6>>>2=-2, -9>>>2=-3.
- Full-scale: prev=0, input 255 → 0,63,127,191. Then input 0 → 255,191,127,63. No wrap to small values.
- Backpressure: during segment 0→100, hold out_ready=0 for 3 cycles after the second beat.
  - out_data stays 25 during the hold.
  - in_ready stays 0 during the hold.
  - Sequence completes 0,25,50,75 with no repeats.
- Flush:
  - After priming with 42, pulse flush → one beat 42, then IDLE, then in_ready=1.
  - Next input 10 primes only, with no output.
  - flush and in_valid together in PRIMED → segment starts and flush is ignored.
- Reset mid-segment: assert reset after the 2nd beat of 0→100.
  - out_valid=0 and out_data=0 immediately.
  - After release, inputs 8, 16 → outputs 8,10,12,14.
